// File: rtl/pll_reconf_ctrl.sv
// pll_reconf_ctrl: captures a PLL scan image from the reconfig ROM, shifts it into the PLL scan chain and issues the update
module pll_reconf_ctrl #(
  parameter int SCAN_BITS    = 144,
  parameter int ROM_LATENCY  = 2,
  parameter int SCANCLK_HALF = 2,
  parameter int DONE_TIMEOUT = 1023
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       trigger_read,
  input  logic       q,
  input  logic       reconfig,
  input  logic       pll_scandone,
  output logic [7:0] address,
  output logic       read_ena,
  output logic       busy,
  output logic       pll_scanclk,
  output logic       pll_scanclkena,
  output logic       pll_scandata,
  output logic       pll_configupdate,
  output logic       error
);
  localparam int IW = SCAN_BITS > 1 ? $clog2(SCAN_BITS) : 1;
  localparam int HW = $clog2(SCANCLK_HALF) + 1;
  localparam int TW = $clog2(DONE_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, READ, TAIL, WAIT_RECONF, SHIFT, UPDATE, WAIT_DONE} state_t;
  state_t state;
  logic [8:0] bit_cnt;
  logic [HW-1:0] half_cnt;
  logic [TW-1:0] to_cnt;
  logic pend;
  logic [SCAN_BITS-1:0] image;
  logic [ROM_LATENCY-1:0] pipe_v;
  logic [IW-1:0] pipe_a [ROM_LATENCY];
  logic [IW-1:0] nidx;
  logic last_half;
  assign nidx = IW'(SCAN_BITS - 2) - bit_cnt[IW-1:0];
  assign last_half = half_cnt == HW'(SCANCLK_HALF - 1);
  // address travels alongside the ROM latency so each bit lands at its own index
  always_ff @(posedge clock) begin
    pipe_a[0] <= address[IW-1:0];
    for (int i = 1; i < ROM_LATENCY; i++) pipe_a[i] <= pipe_a[i-1];
    if (pipe_v[ROM_LATENCY-1]) image[pipe_a[ROM_LATENCY-1]] <= q;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      address          <= '0;
      read_ena         <= 1'b0;
      busy             <= 1'b0;
      pll_scanclk      <= 1'b0;
      pll_scanclkena   <= 1'b0;
      pll_scandata     <= 1'b0;
      pll_configupdate <= 1'b0;
      error            <= 1'b0;
      bit_cnt          <= '0;
      half_cnt         <= '0;
      to_cnt           <= '0;
      pend             <= 1'b0;
      pipe_v           <= '0;
    end else begin
      for (int i = ROM_LATENCY - 1; i > 0; i--) pipe_v[i] <= pipe_v[i-1];
      pipe_v[0]        <= read_ena;
      pll_configupdate <= 1'b0;
      case (state)
        IDLE: if (trigger_read) begin
          state    <= READ;
          busy     <= 1'b1;
          error    <= 1'b0;
          read_ena <= 1'b1;
          address  <= '0;
          pend     <= 1'b0;
        end
        READ: begin
          address <= address == 8'(SCAN_BITS - 1) ? '0 : address + 8'd1;
          if (address == 8'(SCAN_BITS - 1)) begin
            read_ena <= 1'b0;
            bit_cnt  <= '0;
            state    <= TAIL;
          end
        end
        TAIL: begin
          pend    <= pend | reconfig;
          bit_cnt <= bit_cnt + 9'd1;
          if (bit_cnt == 9'(ROM_LATENCY - 1)) state <= WAIT_RECONF;
        end
        WAIT_RECONF: if (reconfig || pend) begin
          state          <= SHIFT;
          pend           <= 1'b0;
          pll_scanclkena <= 1'b1;
          pll_scanclk    <= 1'b0;
          pll_scandata   <= image[SCAN_BITS-1];
          bit_cnt        <= '0;
          half_cnt       <= '0;
        end
        // next bit is presented on each falling scanclk edge, a full half period ahead of the rise
        SHIFT: begin
          half_cnt <= last_half ? '0 : half_cnt + HW'(1);
          if (last_half) begin
            pll_scanclk <= ~pll_scanclk;
            if (pll_scanclk) begin
              bit_cnt      <= bit_cnt + 9'd1;
              pll_scandata <= bit_cnt == 9'(SCAN_BITS - 1) ? 1'b0 : image[nidx];
              if (bit_cnt == 9'(SCAN_BITS - 1)) begin
                pll_scanclkena   <= 1'b0;
                pll_configupdate <= 1'b1;
                state            <= UPDATE;
              end
            end
          end
        end
        UPDATE: begin
          to_cnt <= TW'(1);
          state  <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (pll_scandone) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (to_cnt >= TW'(DONE_TIMEOUT - 1)) begin
            to_cnt <= TW'(DONE_TIMEOUT);
            error  <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pll_reconf_ctrl.sv
// tb_pll_reconf_ctrl: directed bench for pll_reconf_ctrl at default and small (8-bit, half period 1) parameters
module tb_pll_reconf_ctrl;
  logic clock = 1'b0, reset_n = 1'b0, trig = 1'b0, rcfg = 1'b0, sdone = 1'b0, sel = 1'b0, mon_clr = 1'b0;
  always #5 clock = ~clock;
  logic [7:0] addr_m, addr_s, m_addr, d1, d2;
  logic re_m, re_s, busy_m, busy_s, sclk_m, sclk_s, ena_m, ena_s, sdat_m, sdat_s, cu_m, cu_s, err_m, err_s;
  logic m_re, m_busy, m_sclk, m_ena, m_sdat, m_cu, m_err, q;
  logic [14:0] all_m, all_s, m_all;
  logic [7:0] img = 8'hA5;
  logic [255:0] alt, st;
  int n_run = 0, n_fail = 0, n;
  int rise_cnt, cu_cnt, re_cnt, ena_cnt, pmin, pmax, since, bad_chg;
  logic prev_clk, prev_dat;

  pll_reconf_ctrl dut (
    .clock(clock), .reset_n(reset_n), .trigger_read(trig & ~sel), .q(q),
    .reconfig(rcfg & ~sel), .pll_scandone(sdone & ~sel), .address(addr_m), .read_ena(re_m),
    .busy(busy_m), .pll_scanclk(sclk_m), .pll_scanclkena(ena_m), .pll_scandata(sdat_m),
    .pll_configupdate(cu_m), .error(err_m)
  );
  pll_reconf_ctrl #(.SCAN_BITS(8), .SCANCLK_HALF(1)) dut_s (
    .clock(clock), .reset_n(reset_n), .trigger_read(trig & sel), .q(q),
    .reconfig(rcfg & sel), .pll_scandone(sdone & sel), .address(addr_s), .read_ena(re_s),
    .busy(busy_s), .pll_scanclk(sclk_s), .pll_scanclkena(ena_s), .pll_scandata(sdat_s),
    .pll_configupdate(cu_s), .error(err_s)
  );

  assign all_m  = {addr_m, re_m, busy_m, sclk_m, ena_m, sdat_m, cu_m, err_m};
  assign all_s  = {addr_s, re_s, busy_s, sclk_s, ena_s, sdat_s, cu_s, err_s};
  assign m_all  = sel ? all_s : all_m;
  assign m_addr = sel ? addr_s : addr_m;
  assign m_re   = sel ? re_s : re_m;
  assign m_busy = sel ? busy_s : busy_m;
  assign m_sclk = sel ? sclk_s : sclk_m;
  assign m_ena  = sel ? ena_s : ena_m;
  assign m_sdat = sel ? sdat_s : sdat_m;
  assign m_cu   = sel ? cu_s : cu_m;
  assign m_err  = sel ? err_s : err_m;

  // ROM model with two cycles of latency: q = address[0], or bit of 0xA5 for the small instance
  always @(posedge clock) begin
    d1 <= m_addr;
    d2 <= d1;
  end
  assign q = sel ? img[d2[2:0]] : d2[0];

  always @(negedge clock) begin
    if (mon_clr) begin
      rise_cnt = 0; cu_cnt = 0; re_cnt = 0; ena_cnt = 0; pmin = 1000; pmax = 0;
      since = 0; bad_chg = 0; st = '0; prev_clk = 1'b0; prev_dat = 1'b0;
    end else begin
      since++;
      if (m_sclk && !prev_clk) begin
        rise_cnt++;
        st = {st[254:0], m_sdat};
        if (rise_cnt > 1) begin
          if (since < pmin) pmin = since;
          if (since > pmax) pmax = since;
        end
        since = 0;
      end
      if (m_sclk && m_sdat != prev_dat) bad_chg++;
      cu_cnt  += int'(m_cu);
      re_cnt  += int'(m_re);
      ena_cnt += int'(m_ena);
      prev_clk = m_sclk;
      prev_dat = m_sdat;
    end
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic mon_clear();
    mon_clr = 1'b1;
    step();
    mon_clr = 1'b0;
  endtask

  task automatic do_read(input int s, input int rdly);
    trig = 1'b1;
    step();
    trig = 1'b0;
    check("read_start", {m_re, m_busy, m_addr}, {2'b11, 8'd0});
    repeat (s - 1) step();
    check("read_last", {m_re, m_addr}, {1'b1, 8'(s - 1)});
    step();
    check("read_end", {m_re, m_addr}, 9'd0);
    repeat (rdly) step();
    rcfg = 1'b1;
    step();
    rcfg = 1'b0;
  endtask

  task automatic wait_cu(output int cnt);
    cnt = 0;
    while (!m_cu && cnt < 5000) begin
      step();
      cnt++;
    end
    if (!m_cu) cnt = -1;
  endtask

  task automatic check_shift(input int s, input int hp, input logic [255:0] exp_st);
    check("rises", rise_cnt, s);
    check("stream", st, exp_st);
    check("period_min", pmin, 2 * hp);
    check("period_max", pmax, 2 * hp);
    check("ena_cycles", ena_cnt, 2 * hp * s);
    check("data_stable", bad_chg, 0);
    check("read_cycles", re_cnt, s);
  endtask

  task automatic do_done();
    repeat (10) step();
    check("busy_before_done", m_busy, 1);
    sdone = 1'b1;
    step();
    sdone = 1'b0;
    check("busy_after_done", m_busy, 0);
    check("err_after_done", m_err, 0);
    check("cu_pulses", cu_cnt, 1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) alt[i] = (i < 144) ? i[0] : 1'b0;
    repeat (2) step();
    check("rst_m", all_m, 0);
    check("rst_s", all_s, 0);
    reset_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      sel = k[0];
      mon_clear();
      rcfg = 1'b1;
      sdone = 1'b1;
      step();
      rcfg = 1'b0;
      sdone = 1'b0;
      repeat (5) step();
      check("stray_out", m_all, 0);
      check("stray_act", rise_cnt + re_cnt + cu_cnt, 0);
    end
    sel = 1'b0;
    mon_clear();
    do_read(144, 3);
    wait_cu(n);
    check("cu_lat", n, 576);
    check_shift(144, 2, alt);
    do_done();
    mon_clear();
    do_read(144, 0);
    repeat (200) step();
    check("mid_shift", {m_ena, m_busy}, 2'b11);
    trig = 1'b1;
    step();
    trig = 1'b0;
    wait_cu(n);
    check("cu_lat_rt", n, 377);
    check_shift(144, 2, alt);
    do_done();
    repeat (3) step();
    check("no_queue", {m_re, m_busy}, 2'b00);
    mon_clear();
    do_read(144, 3);
    wait_cu(n);
    check("cu_lat_to", n, 576);
    repeat (1022) step();
    check("to_pre", {m_err, m_busy}, 2'b01);
    step();
    check("to_post", {m_err, m_busy}, 2'b10);
    mon_clear();
    do_read(144, 3);
    check("err_clr", m_err, 0);
    n = 0;
    while (rise_cnt < 70 && n < 2000) begin
      step();
      n++;
    end
    check("reach_bit70", rise_cnt, 70);
    reset_n = 1'b0;
    #1;
    check("async_rst", m_all, 0);
    step();
    reset_n = 1'b1;
    repeat (3) step();
    check("no_cu_aborted", cu_cnt, 0);
    mon_clear();
    do_read(144, 3);
    wait_cu(n);
    check("cu_lat_rr", n, 576);
    check_shift(144, 2, alt);
    do_done();
    sel = 1'b1;
    mon_clear();
    do_read(8, 3);
    wait_cu(n);
    check("cu_lat_s", n, 16);
    check_shift(8, 1, 256'hA5);
    do_done();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
